// File: rtl/fifo_serial_tx.sv
// Fifo consumer that drains one word per async serial frame: start bit, DATA_W data bits
// LSB-first, stop bit. Every output is driven straight from a flop.
module fifo_serial_tx #(
  parameter int DATA_W       = 4,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_read,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int              IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [15:0]     TC       = 16'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [15:0]         timer_q, timer_d;
  logic [IDX_W-1:0]    bit_q, bit_d;
  logic                tx_q, tx_d;
  logic                read_q, read_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                bit_end;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    timer_d = timer_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    read_d  = 1'b0;
    bit_end = (timer_q == TC);

    case (state_q)
      IDLE: begin
        tx_d    = 1'b1;
        timer_d = '0;
        bit_d   = '0;
        if (enable && !fifo_empty) begin
          state_d = FETCH;
          read_d  = 1'b1;
        end
      end
      // Fifo pops at the edge closing this state; its output is valid in CAPTURE.
      FETCH: state_d = CAPTURE;
      CAPTURE: begin
        shift_d = fifo_data;
        timer_d = '0;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          timer_d = '0;
          tx_d    = shift_q[0];
          state_d = DATA;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      DATA: begin
        if (bit_end) begin
          timer_d = '0;
          if (bit_q == LAST_BIT) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d   = bit_q + 1'b1;
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      STOP: begin
        if (bit_end) begin
          timer_d = '0;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered flags look ahead at the next state so they line up with it.
    busy_d = (state_d != IDLE);
    done_d = (state_d == STOP) && (timer_d == TC);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      timer_q <= '0;
      bit_q   <= '0;
      tx_q    <= 1'b1;
      read_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      read_q  <= read_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign fifo_read  = read_q;
  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_fifo_serial_tx.sv
// Bench for fifo_serial_tx: fifo models feed two instances (4 and 1 clocks per bit),
// and a scoreboard of queued words is checked against the decoded serial frames.
module tb_fifo_serial_tx;
  localparam int W   = 4;
  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, enable, enable1;
  logic [W-1:0] fifo_data, fifo_data1;
  logic         fifo_empty, fifo_empty1;
  logic         fifo_read, fifo_read1;
  logic         tx, tx1, busy, busy1, frame_done, frame_done1;

  logic [W-1:0] mem_a [64];
  logic [W-1:0] mem_b [64];
  logic [W-1:0] expa[$];
  logic [W-1:0] expb[$];
  int wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;
  int reads = 0, reads1 = 0, bad_reads = 0, bad_reads1 = 0;
  int fd_cnt = 0, busy_run = 0, last_busy_run = 0;
  int checks = 0, errors = 0;
  int waited, w2, r0, f0, n;

  fifo_serial_tx #(.DATA_W(W), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_read(fifo_read), .tx(tx), .busy(busy), .frame_done(frame_done));

  fifo_serial_tx #(.DATA_W(W), .CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable1), .fifo_empty(fifo_empty1), .fifo_data(fifo_data1),
    .fifo_read(fifo_read1), .tx(tx1), .busy(busy1), .frame_done(frame_done1));

  // Synchronous fifo models: registered data_out valid the cycle after the strobe.
  assign fifo_empty  = (wr_a == rd_a);
  assign fifo_empty1 = (wr_b == rd_b);

  always @(posedge clk) begin
    if (fifo_read === 1'b1) begin
      reads <= reads + 1;
      if (wr_a == rd_a) bad_reads <= bad_reads + 1;
      else begin
        fifo_data <= mem_a[rd_a];
        rd_a      <= rd_a + 1;
      end
    end
  end

  always @(posedge clk) begin
    if (fifo_read1 === 1'b1) begin
      reads1 <= reads1 + 1;
      if (wr_b == rd_b) bad_reads1 <= bad_reads1 + 1;
      else begin
        fifo_data1 <= mem_b[rd_b];
        rd_b       <= rd_b + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (frame_done === 1'b1) fd_cnt++;
    if (busy === 1'b1) busy_run++;
    else if (busy_run != 0) begin
      last_busy_run = busy_run;
      busy_run      = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input bit sel, input logic [W-1:0] w);
    if (!sel) begin
      mem_a[wr_a] = w;
      wr_a++;
      expa.push_back(w);
    end else begin
      mem_b[wr_b] = w;
      wr_b++;
      expb.push_back(w);
    end
  endtask

  function automatic logic cur_tx(input bit sel);
    return sel ? tx1 : tx;
  endfunction

  function automatic logic cur_fd(input bit sel);
    return sel ? frame_done1 : frame_done;
  endfunction

  // Waits for a start bit, then checks every cycle of the frame against the scoreboard word.
  task automatic expect_frame(input bit sel, input int max_wait, output int wcnt);
    int cpb, len, idx, qs;
    logic [W-1:0] w;
    logic e;
    cpb  = sel ? 1 : CPB;
    len  = (W + 2) * cpb;
    wcnt = 0;
    @(negedge clk);
    while (cur_tx(sel) !== 1'b0 && wcnt < max_wait) begin
      wcnt++;
      @(negedge clk);
    end
    if (cur_tx(sel) !== 1'b0) begin
      chk("frame_start", {31'd0, cur_tx(sel)}, 32'd0);
      return;
    end
    qs = sel ? expb.size() : expa.size();
    if (qs == 0) begin
      chk("scoreboard_size", qs, 1);
      return;
    end
    w = sel ? expb.pop_front() : expa.pop_front();
    for (int k = 0; k < len; k++) begin
      if (k != 0) @(negedge clk);
      idx = k / cpb;
      if (idx == 0)      e = 1'b0;
      else if (idx <= W) e = w[idx-1];
      else               e = 1'b1;
      chk($sformatf("tx_w%0h_c%0d", w, k), {31'd0, cur_tx(sel)}, {31'd0, e});
      chk($sformatf("frame_done_w%0h_c%0d", w, k), {31'd0, cur_fd(sel)}, (k == len - 1) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; enable1 = 1'b0;

    // Reset asserted mid-cycle takes effect before any clock edge.
    #3 rst = 1'b1;
    #1;
    chk("rst_tx", {31'd0, tx}, 32'd1);
    chk("rst_fifo_read", {31'd0, fifo_read}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("rst_tx1", {31'd0, tx1}, 32'd1);
    chk("rst_busy1", {31'd0, busy1}, 32'd0);
    repeat (3) @(negedge clk);
    chk("rst_hold_tx", {31'd0, tx}, 32'd1);
    chk("rst_hold_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single word 0xA.
    enable = 1'b1;
    r0 = reads; f0 = fd_cnt;
    push(0, 4'hA);
    expect_frame(0, 20, waited);
    chk("latency_to_start", waited, 2);
    repeat (3) @(negedge clk);
    chk("single_reads", reads - r0, 1);
    chk("single_frame_done_pulses", fd_cnt - f0, 1);
    chk("single_busy_cycles", last_busy_run, (W + 2) * CPB + 2);
    chk("single_idle_busy", {31'd0, busy}, 32'd0);

    // Back-to-back words 0x3 then 0xC.
    r0 = reads;
    push(0, 4'h3);
    push(0, 4'hC);
    expect_frame(0, 20, waited);
    expect_frame(0, 20, w2);
    chk("b2b_high_gap", w2 + CPB, 7);
    repeat (3) @(negedge clk);
    chk("b2b_reads", reads - r0, 2);

    // enable low holds off reads; dropping it mid-frame lets the frame finish.
    enable = 1'b0;
    push(0, 4'h7);
    push(0, 4'h9);
    push(0, 4'h6);
    r0 = reads;
    repeat (50) @(negedge clk);
    chk("disabled_reads", reads - r0, 0);
    chk("disabled_tx", {31'd0, tx}, 32'd1);
    chk("disabled_busy", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    fork
      expect_frame(0, 20, waited);
      begin
        repeat (10) @(negedge clk);
        enable = 1'b0;
      end
    join
    repeat (50) @(negedge clk);
    chk("enable_drop_reads", reads - r0, 1);
    chk("enable_drop_fifo_left", wr_a - rd_a, 2);
    chk("enable_drop_tx", {31'd0, tx}, 32'd1);

    // Reset during the second data bit abandons the frame (word 0x9 is lost).
    enable = 1'b1;
    @(negedge clk);
    n = 0;
    while (tx !== 1'b0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("abort_frame_start", {31'd0, tx}, 32'd0);
    repeat (2 * CPB + 1) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_tx", {31'd0, tx}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_fifo_read", {31'd0, fifo_read}, 32'd0);
    chk("abort_frame_done", {31'd0, frame_done}, 32'd0);
    void'(expa.pop_front());
    @(negedge clk);
    chk("abort_hold_tx", {31'd0, tx}, 32'd1);
    rst = 1'b0;
    expect_frame(0, 20, waited);
    repeat (3) @(negedge clk);
    chk("abort_reads", reads - r0, 3);
    chk("abort_fifo_drained", wr_a - rd_a, 0);

    // One clock per bit, word 0x5.
    enable1 = 1'b1;
    push(1, 4'h5);
    expect_frame(1, 20, waited);
    chk("cpb1_latency", waited, 2);
    repeat (3) @(negedge clk);
    chk("cpb1_reads", reads1, 1);
    chk("bad_reads", bad_reads, 0);
    chk("bad_reads1", bad_reads1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
